// File: rtl/commit_rob_pkg.sv
// Shared sizes and types for the in-order commit buffer (commit_rob).
package commit_rob_pkg;

    localparam int RobNum   = 16;
    localparam int RobTagW  = $clog2(RobNum);
    localparam int RegAddrW = 5;
    localparam int RegW     = 32;

    typedef logic [RobTagW-1:0]  robTag_t;
    typedef logic [RobTagW:0]    robCount_t;
    typedef logic [RegAddrW-1:0] regAddr_t;
    typedef logic [RegW-1:0]     regData_t;

    localparam robCount_t RobFull = robCount_t'(RobNum);

endpackage

// File: rtl/commit_rob_if.sv
// Issue/CDB/commit signal bundle of the commit buffer; master is the pipeline side, slave is the ROB.
// The fwd_* lookup signals exist only when ROB_FWD_EN is defined.
interface commit_rob_if;
    import commit_rob_pkg::*;

    logic      alloc_valid;
    regAddr_t  alloc_rd;
    logic      alloc_ready;
    robTag_t   alloc_tag;

    logic      cdb_valid;
    robTag_t   cdb_tag;
    regData_t  cdb_data;

    logic      flush;

    logic      commit_we;
    regAddr_t  commit_addr;
    regData_t  commit_data;
    robTag_t   commit_tag;

    logic      empty;
    robCount_t count;

`ifdef ROB_FWD_EN
    robTag_t   fwd_tag;
    logic      fwd_hit;
    regData_t  fwd_data;
`endif

    modport master (
        output alloc_valid, alloc_rd, cdb_valid, cdb_tag, cdb_data, flush,
        input  alloc_ready, alloc_tag, commit_we, commit_addr, commit_data, commit_tag,
        input  empty, count
`ifdef ROB_FWD_EN
        , output fwd_tag
        , input  fwd_hit, fwd_data
`endif
    );

    modport slave (
        input  alloc_valid, alloc_rd, cdb_valid, cdb_tag, cdb_data, flush,
        output alloc_ready, alloc_tag, commit_we, commit_addr, commit_data, commit_tag,
        output empty, count
`ifdef ROB_FWD_EN
        , input  fwd_tag
        , output fwd_hit, fwd_data
`endif
    );

endinterface

// File: rtl/commit_rob.sv
// In-order commit buffer: grants tags at issue, collects CDB results, retires in program order to the RF port.
// Define ROB_FWD_EN to add a combinational lookup of stored results by tag.
module commit_rob
    import commit_rob_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    commit_rob_if.slave  rob_io
);

    logic [RobNum-1:0] busy_q;
    logic [RobNum-1:0] ready_q;
    regAddr_t          rd_q   [RobNum];
    regData_t          data_q [RobNum];

    robTag_t   headPtr_q, headPtr_d;
    robTag_t   tailPtr_q, tailPtr_d;
    robCount_t count_q,   count_d;

    logic      commitWe_q;
    regAddr_t  commitAddr_q;
    regData_t  commitData_q;
    robTag_t   commitTag_q;

    logic allocReady;
    logic doAlloc;
    logic doRetire;
    logic doCdb;

    assign allocReady = (count_q != RobFull);
    assign doAlloc    = rob_io.alloc_valid && allocReady && !rob_io.flush;
    assign doRetire   = busy_q[headPtr_q] && ready_q[headPtr_q] && !rob_io.flush;
    // A result aimed at the slot being allocated this edge belongs to a stale instruction, so it is dropped.
    assign doCdb      = rob_io.cdb_valid && busy_q[rob_io.cdb_tag] && !rob_io.flush
                        && !(doAlloc && (rob_io.cdb_tag == tailPtr_q));

    always_comb begin
        headPtr_d = headPtr_q;
        tailPtr_d = tailPtr_q;
        count_d   = count_q;
        if (rob_io.flush) begin
            headPtr_d = '0;
            tailPtr_d = '0;
            count_d   = '0;
        end else begin
            if (doAlloc)  tailPtr_d = tailPtr_q + robTag_t'(1);
            if (doRetire) headPtr_d = headPtr_q + robTag_t'(1);
            case ({doAlloc, doRetire})
                2'b10:   count_d = count_q + robCount_t'(1);
                2'b01:   count_d = count_q - robCount_t'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q       <= '0;
            ready_q      <= '0;
            headPtr_q    <= '0;
            tailPtr_q    <= '0;
            count_q      <= '0;
            commitWe_q   <= 1'b0;
            commitAddr_q <= '0;
            commitData_q <= '0;
            commitTag_q  <= '0;
        end else begin
            headPtr_q <= headPtr_d;
            tailPtr_q <= tailPtr_d;
            count_q   <= count_d;
            if (rob_io.flush) begin
                busy_q     <= '0;
                ready_q    <= '0;
                commitWe_q <= 1'b0;
            end else begin
                if (doCdb) begin
                    ready_q[rob_io.cdb_tag] <= 1'b1;
                end
                if (doAlloc) begin
                    busy_q[tailPtr_q]  <= 1'b1;
                    ready_q[tailPtr_q] <= 1'b0;
                end
                // x0 writes still retire and update the commit bus, but never assert the RF write enable.
                if (doRetire) begin
                    busy_q[headPtr_q] <= 1'b0;
                    commitWe_q        <= (rd_q[headPtr_q] != '0);
                    commitAddr_q      <= rd_q[headPtr_q];
                    commitData_q      <= data_q[headPtr_q];
                    commitTag_q       <= headPtr_q;
                end else begin
                    commitWe_q <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (doAlloc) rd_q[tailPtr_q]        <= rob_io.alloc_rd;
        if (doCdb)   data_q[rob_io.cdb_tag] <= rob_io.cdb_data;
    end

    assign rob_io.alloc_ready = allocReady;
    assign rob_io.alloc_tag   = tailPtr_q;
    assign rob_io.commit_we   = commitWe_q;
    assign rob_io.commit_addr = commitAddr_q;
    assign rob_io.commit_data = commitData_q;
    assign rob_io.commit_tag  = commitTag_q;
    assign rob_io.empty       = (count_q == '0);
    assign rob_io.count       = count_q;

`ifdef ROB_FWD_EN
    // Lookup sees stored state only; a same-cycle CDB broadcast is not bypassed.
    assign rob_io.fwd_hit  = busy_q[rob_io.fwd_tag] & ready_q[rob_io.fwd_tag];
    assign rob_io.fwd_data = data_q[rob_io.fwd_tag];
`endif

endmodule

// File: tb/tb_commit_rob.sv
// Self-checking bench for commit_rob: directed scenarios plus randomized traffic against a queue-based model.
// With ROB_FWD_EN defined the random scenario also checks the fwd lookup.
module tb_commit_rob;
    import commit_rob_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    commit_rob_if rob_io();
    commit_rob dut (.clk(clk), .rst(rst), .rob_io(rob_io));

    int checks = 0;
    int passed = 0;

    // Program-order model: index 0 is the oldest in-flight instruction.
    typedef struct {
        int       tag;
        regAddr_t rd;
        bit       rdy;
        regData_t data;
    } mEntry_t;

    mEntry_t  mq[$];
    int       mHead;
    logic     eWe;
    regAddr_t eAddr;
    regData_t eData;
    robTag_t  eTag;

    task automatic modelReset();
        mq.delete();
        mHead = 0;
        eWe   = 1'b0;
        eAddr = '0;
        eData = '0;
        eTag  = '0;
    endtask

    task automatic modelStep();
        mEntry_t oldest;
        bit      ret;
        bit      allocOk;
        int      allocTag;
        if (rob_io.flush) begin
            mq.delete();
            mHead = 0;
            eWe   = 1'b0;
            return;
        end
        ret      = (mq.size() > 0) && mq[0].rdy;
        oldest   = ret ? mq[0] : '{0, '0, 1'b0, '0};
        allocOk  = rob_io.alloc_valid && (mq.size() < RobNum);
        allocTag = (mHead + mq.size()) % RobNum;
        if (rob_io.cdb_valid) begin
            foreach (mq[i]) begin
                if (mq[i].tag == int'(rob_io.cdb_tag)) begin
                    mq[i].rdy  = 1'b1;
                    mq[i].data = rob_io.cdb_data;
                end
            end
        end
        if (allocOk) mq.push_back('{allocTag, rob_io.alloc_rd, 1'b0, '0});
        if (ret) begin
            void'(mq.pop_front());
            mHead = (mHead + 1) % RobNum;
            eWe   = (oldest.rd != '0);
            eAddr = oldest.rd;
            eData = oldest.data;
            eTag  = robTag_t'(oldest.tag);
        end else begin
            eWe = 1'b0;
        end
    endtask

    task automatic clearInputs();
        rob_io.alloc_valid = 1'b0;
        rob_io.alloc_rd    = '0;
        rob_io.cdb_valid   = 1'b0;
        rob_io.cdb_tag     = '0;
        rob_io.cdb_data    = '0;
        rob_io.flush       = 1'b0;
`ifdef ROB_FWD_EN
        rob_io.fwd_tag     = '0;
`endif
    endtask

    // Drive one cycle of inputs at the falling edge, advance the model, sample 1ns after the rising edge.
    task automatic applyStimulus(input logic av, input regAddr_t rd, input logic cv,
                                 input robTag_t ct, input regData_t cd, input logic fl);
        @(negedge clk);
        rob_io.alloc_valid = av;
        rob_io.alloc_rd    = rd;
        rob_io.cdb_valid   = cv;
        rob_io.cdb_tag     = ct;
        rob_io.cdb_data    = cd;
        rob_io.flush       = fl;
`ifdef ROB_FWD_EN
        rob_io.fwd_tag     = robTag_t'($urandom_range(0, RobNum-1));
`endif
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        clearInputs();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        modelReset();
    endtask

    task automatic test_reset();
        @(posedge clk);
        #2;
        checks++; if (rob_io.empty !== 1'b1) $display("[TB] FAIL reset_empty actual=%0b expected=1", rob_io.empty); else passed++;
        checks++; if (rob_io.alloc_ready !== 1'b1) $display("[TB] FAIL reset_alloc_ready actual=%0b expected=1", rob_io.alloc_ready); else passed++;
        checks++; if (rob_io.commit_we !== 1'b0) $display("[TB] FAIL reset_commit_we actual=%0b expected=0", rob_io.commit_we); else passed++;
        checks++; if (rob_io.alloc_tag !== 4'd0) $display("[TB] FAIL reset_alloc_tag actual=%0d expected=0", rob_io.alloc_tag); else passed++;
        checks++; if (rob_io.count !== 5'd0) $display("[TB] FAIL reset_count actual=%0d expected=0", rob_io.count); else passed++;
        checks++; if (rob_io.commit_data !== 32'd0) $display("[TB] FAIL reset_commit_data actual=%0h expected=0", rob_io.commit_data); else passed++;
        @(negedge clk);
        rst = 1'b0;
        modelReset();
    endtask

    task automatic test_single();
        doReset();
        applyStimulus(1'b1, 5'd3, 1'b0, 4'd0, 32'd0, 1'b0);
        checks++; if (rob_io.count !== 5'd1) $display("[TB] FAIL single_count actual=%0d expected=1", rob_io.count); else passed++;
        checks++; if (rob_io.alloc_tag !== 4'd1) $display("[TB] FAIL single_tail actual=%0d expected=1", rob_io.alloc_tag); else passed++;
        applyStimulus(1'b0, 5'd0, 1'b1, 4'd0, 32'hDEADBEEF, 1'b0);
        checks++; if (rob_io.commit_we !== 1'b0) $display("[TB] FAIL single_early_we actual=%0b expected=0", rob_io.commit_we); else passed++;
        applyStimulus(1'b0, 5'd0, 1'b0, 4'd0, 32'd0, 1'b0);
        checks++; if (rob_io.commit_we !== 1'b1) $display("[TB] FAIL single_we actual=%0b expected=1", rob_io.commit_we); else passed++;
        checks++; if (rob_io.commit_addr !== 5'd3) $display("[TB] FAIL single_addr actual=%0d expected=3", rob_io.commit_addr); else passed++;
        checks++; if (rob_io.commit_data !== 32'hDEADBEEF) $display("[TB] FAIL single_data actual=%0h expected=deadbeef", rob_io.commit_data); else passed++;
        checks++; if (rob_io.empty !== 1'b1) $display("[TB] FAIL single_empty actual=%0b expected=1", rob_io.empty); else passed++;
        applyStimulus(1'b0, 5'd0, 1'b0, 4'd0, 32'd0, 1'b0);
        checks++; if (rob_io.commit_we !== 1'b0) $display("[TB] FAIL single_pulse actual=%0b expected=0", rob_io.commit_we); else passed++;
    endtask

    task automatic test_in_order();
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, regAddr_t'(i + 1), 1'b0, 4'd0, 32'd0, 1'b0);
        for (int i = 2; i >= 0; i--) begin
            applyStimulus(1'b0, 5'd0, 1'b1, robTag_t'(i), 32'h1000_0000 + 32'(i), 1'b0);
            checks++; if (rob_io.commit_we !== 1'b0) $display("[TB] FAIL order_early_we%0d actual=%0b expected=0", i, rob_io.commit_we); else passed++;
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 5'd0, 1'b0, 4'd0, 32'd0, 1'b0);
            checks++; if (rob_io.commit_we !== 1'b1) $display("[TB] FAIL order_we%0d actual=%0b expected=1", k, rob_io.commit_we); else passed++;
            checks++; if (rob_io.commit_tag !== robTag_t'(k)) $display("[TB] FAIL order_tag%0d actual=%0d expected=%0d", k, rob_io.commit_tag, k); else passed++;
            checks++; if (rob_io.commit_data !== 32'h1000_0000 + 32'(k)) $display("[TB] FAIL order_data%0d actual=%0h expected=%0h", k, rob_io.commit_data, 32'h1000_0000 + 32'(k)); else passed++;
        end
        checks++; if (rob_io.empty !== 1'b1) $display("[TB] FAIL order_empty actual=%0b expected=1", rob_io.empty); else passed++;
    endtask

    task automatic test_full();
        doReset();
        for (int i = 0; i < RobNum; i++) applyStimulus(1'b1, regAddr_t'(i + 1), 1'b0, 4'd0, 32'd0, 1'b0);
        checks++; if (rob_io.count !== 5'd16) $display("[TB] FAIL full_count actual=%0d expected=16", rob_io.count); else passed++;
        checks++; if (rob_io.alloc_ready !== 1'b0) $display("[TB] FAIL full_ready actual=%0b expected=0", rob_io.alloc_ready); else passed++;
        checks++; if (rob_io.alloc_tag !== 4'd0) $display("[TB] FAIL full_tail_wrap actual=%0d expected=0", rob_io.alloc_tag); else passed++;
        applyStimulus(1'b1, 5'd7, 1'b0, 4'd0, 32'd0, 1'b0);
        checks++; if (rob_io.count !== 5'd16) $display("[TB] FAIL full_17th_count actual=%0d expected=16", rob_io.count); else passed++;
        applyStimulus(1'b1, 5'd7, 1'b1, 4'd0, 32'hA0A0_0000, 1'b0);
        checks++; if (rob_io.count !== 5'd16) $display("[TB] FAIL full_cdb_count actual=%0d expected=16", rob_io.count); else passed++;
        applyStimulus(1'b1, 5'd9, 1'b0, 4'd0, 32'd0, 1'b0);
        checks++; if (rob_io.commit_we !== 1'b1 || rob_io.commit_tag !== 4'd0) $display("[TB] FAIL full_retire we=%0b tag=%0d expected we=1 tag=0", rob_io.commit_we, rob_io.commit_tag); else passed++;
        checks++; if (rob_io.count !== 5'd15) $display("[TB] FAIL full_retire_count actual=%0d expected=15", rob_io.count); else passed++;
        checks++; if (rob_io.alloc_ready !== 1'b1) $display("[TB] FAIL full_retire_ready actual=%0b expected=1", rob_io.alloc_ready); else passed++;
        applyStimulus(1'b1, 5'd9, 1'b0, 4'd0, 32'd0, 1'b0);
        checks++; if (rob_io.count !== 5'd16) $display("[TB] FAIL full_refill_count actual=%0d expected=16", rob_io.count); else passed++;
        checks++; if (rob_io.alloc_tag !== 4'd1) $display("[TB] FAIL full_refill_tail actual=%0d expected=1", rob_io.alloc_tag); else passed++;
        applyStimulus(1'b0, 5'd0, 1'b1, 4'd1, 32'hA0A0_0001, 1'b0);
        applyStimulus(1'b0, 5'd0, 1'b1, 4'd2, 32'hA0A0_0002, 1'b0);
        checks++; if (rob_io.count !== 5'd15) $display("[TB] FAIL full_drain_count actual=%0d expected=15", rob_io.count); else passed++;
        applyStimulus(1'b1, 5'd4, 1'b0, 4'd0, 32'd0, 1'b0);
        checks++; if (rob_io.count !== 5'd15) $display("[TB] FAIL full_simul_count actual=%0d expected=15", rob_io.count); else passed++;
        checks++; if (rob_io.commit_tag !== 4'd2 || rob_io.commit_data !== 32'hA0A0_0002) $display("[TB] FAIL full_simul_commit tag=%0d data=%0h expected tag=2 data=a0a00002", rob_io.commit_tag, rob_io.commit_data); else passed++;
        checks++; if (rob_io.alloc_tag !== 4'd2) $display("[TB] FAIL full_simul_tail actual=%0d expected=2", rob_io.alloc_tag); else passed++;
    endtask

    task automatic test_rd_zero();
        doReset();
        applyStimulus(1'b1, 5'd0, 1'b0, 4'd0, 32'd0, 1'b0);
        applyStimulus(1'b0, 5'd0, 1'b1, 4'd0, 32'h0000_55AA, 1'b0);
        checks++; if (rob_io.count !== 5'd1) $display("[TB] FAIL rd0_pre_count actual=%0d expected=1", rob_io.count); else passed++;
        applyStimulus(1'b0, 5'd0, 1'b0, 4'd0, 32'd0, 1'b0);
        checks++; if (rob_io.commit_we !== 1'b0) $display("[TB] FAIL rd0_we actual=%0b expected=0", rob_io.commit_we); else passed++;
        checks++; if (rob_io.count !== 5'd0) $display("[TB] FAIL rd0_count actual=%0d expected=0", rob_io.count); else passed++;
        checks++; if (rob_io.commit_data !== 32'h0000_55AA) $display("[TB] FAIL rd0_data actual=%0h expected=55aa", rob_io.commit_data); else passed++;
    endtask

    task automatic test_flush();
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, regAddr_t'(i + 1), 1'b0, 4'd0, 32'd0, 1'b0);
        applyStimulus(1'b0, 5'd0, 1'b1, 4'd1, 32'hF1, 1'b0);
        applyStimulus(1'b0, 5'd0, 1'b1, 4'd0, 32'hF0, 1'b0);
        applyStimulus(1'b1, 5'd12, 1'b1, 4'd2, 32'hF2, 1'b1);
        checks++; if (rob_io.count !== 5'd0) $display("[TB] FAIL flush_count actual=%0d expected=0", rob_io.count); else passed++;
        checks++; if (rob_io.alloc_tag !== 4'd0) $display("[TB] FAIL flush_tail actual=%0d expected=0", rob_io.alloc_tag); else passed++;
        checks++; if (rob_io.empty !== 1'b1) $display("[TB] FAIL flush_empty actual=%0b expected=1", rob_io.empty); else passed++;
        checks++; if (rob_io.commit_we !== 1'b0) $display("[TB] FAIL flush_we actual=%0b expected=0", rob_io.commit_we); else passed++;
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b0, 5'd0, 1'b0, 4'd0, 32'd0, 1'b0);
            checks++; if (rob_io.commit_we !== 1'b0) $display("[TB] FAIL flush_after_we%0d actual=%0b expected=0", k, rob_io.commit_we); else passed++;
        end
        applyStimulus(1'b1, 5'd6, 1'b0, 4'd0, 32'd0, 1'b0);
        checks++; if (rob_io.alloc_tag !== 4'd1 || rob_io.count !== 5'd1) $display("[TB] FAIL flush_realloc tail=%0d count=%0d expected tail=1 count=1", rob_io.alloc_tag, rob_io.count); else passed++;
    endtask

    task automatic test_async_reset();
        doReset();
        applyStimulus(1'b1, 5'd7, 1'b0, 4'd0, 32'd0, 1'b0);
        applyStimulus(1'b1, 5'd8, 1'b1, 4'd0, 32'h7777, 1'b0);
        applyStimulus(1'b1, 5'd9, 1'b0, 4'd0, 32'd0, 1'b0);
        checks++; if (rob_io.commit_we !== 1'b1) $display("[TB] FAIL arst_pre_we actual=%0b expected=1", rob_io.commit_we); else passed++;
        #1 rst = 1'b1;
        #1;
        checks++; if (rob_io.commit_we !== 1'b0) $display("[TB] FAIL arst_we actual=%0b expected=0", rob_io.commit_we); else passed++;
        checks++; if (rob_io.count !== 5'd0 || rob_io.empty !== 1'b1) $display("[TB] FAIL arst_count count=%0d empty=%0b expected 0/1", rob_io.count, rob_io.empty); else passed++;
        checks++; if (rob_io.alloc_tag !== 4'd0 || rob_io.alloc_ready !== 1'b1) $display("[TB] FAIL arst_alloc tag=%0d ready=%0b expected 0/1", rob_io.alloc_tag, rob_io.alloc_ready); else passed++;
        checks++; if (rob_io.commit_addr !== 5'd0 || rob_io.commit_data !== 32'd0) $display("[TB] FAIL arst_commit addr=%0d data=%0h expected 0/0", rob_io.commit_addr, rob_io.commit_data); else passed++;
        #1 rst = 1'b0;
        modelReset();
    endtask

    task automatic test_random();
        int       allocPct;
        int       cdbPct;
        logic     av;
        logic     cv;
        logic     fl;
        regAddr_t rd;
        robTag_t  ct;
        regData_t cd;
        doReset();
        for (int c = 0; c < 400; c++) begin
            allocPct = (c < 200) ? 75 : 40;
            cdbPct   = (c < 200) ? 40 : 80;
            av = ($urandom_range(0, 99) < allocPct);
            cv = ($urandom_range(0, 99) < cdbPct);
            fl = ($urandom_range(0, 63) == 0);
            rd = regAddr_t'($urandom_range(0, 31));
            cd = $urandom;
            if (mq.size() > 0 && $urandom_range(0, 3) != 0) ct = robTag_t'(mq[$urandom_range(0, mq.size() - 1)].tag);
            else ct = robTag_t'($urandom_range(0, RobNum - 1));
            applyStimulus(av, rd, cv, ct, cd, fl);
            checks++; if (rob_io.commit_we !== eWe) $display("[TB] FAIL rnd_we cyc=%0d actual=%0b expected=%0b", c, rob_io.commit_we, eWe); else passed++;
            checks++; if (rob_io.commit_addr !== eAddr) $display("[TB] FAIL rnd_addr cyc=%0d actual=%0d expected=%0d", c, rob_io.commit_addr, eAddr); else passed++;
            checks++; if (rob_io.commit_data !== eData) $display("[TB] FAIL rnd_data cyc=%0d actual=%0h expected=%0h", c, rob_io.commit_data, eData); else passed++;
            checks++; if (rob_io.commit_tag !== eTag) $display("[TB] FAIL rnd_tag cyc=%0d actual=%0d expected=%0d", c, rob_io.commit_tag, eTag); else passed++;
            checks++; if (rob_io.count !== robCount_t'(mq.size())) $display("[TB] FAIL rnd_count cyc=%0d actual=%0d expected=%0d", c, rob_io.count, mq.size()); else passed++;
            checks++; if (rob_io.empty !== (mq.size() == 0)) $display("[TB] FAIL rnd_empty cyc=%0d actual=%0b expected=%0b", c, rob_io.empty, mq.size() == 0); else passed++;
            checks++; if (rob_io.alloc_ready !== (mq.size() < RobNum)) $display("[TB] FAIL rnd_ready cyc=%0d actual=%0b expected=%0b", c, rob_io.alloc_ready, mq.size() < RobNum); else passed++;
            checks++; if (rob_io.alloc_tag !== robTag_t'((mHead + mq.size()) % RobNum)) $display("[TB] FAIL rnd_alloc_tag cyc=%0d actual=%0d expected=%0d", c, rob_io.alloc_tag, (mHead + mq.size()) % RobNum); else passed++;
`ifdef ROB_FWD_EN
            begin
                bit       expHit;
                regData_t expFwd;
                expHit = 1'b0;
                expFwd = '0;
                foreach (mq[i]) begin
                    if (mq[i].tag == int'(rob_io.fwd_tag) && mq[i].rdy) begin
                        expHit = 1'b1;
                        expFwd = mq[i].data;
                    end
                end
                checks++; if (rob_io.fwd_hit !== expHit) $display("[TB] FAIL rnd_fwd_hit cyc=%0d actual=%0b expected=%0b", c, rob_io.fwd_hit, expHit); else passed++;
                if (expHit) begin
                    checks++; if (rob_io.fwd_data !== expFwd) $display("[TB] FAIL rnd_fwd_data cyc=%0d actual=%0h expected=%0h", c, rob_io.fwd_data, expFwd); else passed++;
                end
            end
`endif
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        clearInputs();
        modelReset();
        test_reset();
        test_single();
        test_in_order();
        test_full();
        test_rd_zero();
        test_flush();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
